// File: rtl/cpkt_wrr_sched.sv
// Weighted round-robin scheduler for the tcp_rx control-packet mux path.
// Picks one eligible channel per slot, then holds a CELLSZ-read window followed by GAP idle cycles.
module cpkt_wrr_sched #(
  parameter int UNUM         = 16,
  parameter int ID_WID       = $clog2(UNUM),
  parameter int WWID         = 4,
  parameter int WT_RST       = 1,
  parameter int CELLSZ       = 1,
  parameter int GAP          = 2,
  parameter bit CHN0_HPRIORY = 1'b0,
  parameter int DBG_WID      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [UNUM-1:0]    req,
  input  logic               out_nafull,
  input  logic               cfg_wen,
  input  logic [ID_WID-1:0]  cfg_addr,
  input  logic [WWID-1:0]    cfg_wdata,
  output logic               gnt_vld,
  output logic [UNUM-1:0]    gnt,
  output logic [ID_WID-1:0]  gnt_id,
  output logic               busy,
  output logic [DBG_WID-1:0] dbg_sig
);

  localparam int WIN = CELLSZ + GAP;
  localparam int CW  = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WID-1:0]   ptr_q, ptr_d;
  logic [WWID-1:0]     credit_q, credit_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                gnt_vld_q, gnt_vld_d;
  logic [UNUM-1:0]     gnt_q, gnt_d;
  logic [ID_WID-1:0]   gnt_id_q, gnt_id_d;
  logic                busy_q, busy_d;
  logic [WWID-1:0]     weight_q [UNUM];

  logic [UNUM-1:0]     elig;
  logic [ID_WID-1:0]   scan_id;
  logic                hp_win;
  logic                keep_ptr;
  logic [CW-1:0]       cnt_nxt;

  for (genvar gi = 0; gi < UNUM; gi++) begin : g_elig
    assign elig[gi] = req[gi] & (weight_q[gi] != '0);
  end

  // Circular scan starting after ptr; ptr itself is visited last so a lone
  // eligible channel at ptr gets its credit reloaded.
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    scan_id = ptr_q;
    for (int off = 1; off <= UNUM; off++) begin
      idx = (int'(ptr_q) + off) % UNUM;
      if (!found && elig[idx]) begin
        found   = 1'b1;
        scan_id = ID_WID'(idx);
      end
    end
  end

  assign hp_win   = CHN0_HPRIORY && elig[0];
  assign keep_ptr = elig[ptr_q] && (credit_q != '0);
  assign cnt_nxt  = cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    credit_d  = credit_q;
    cnt_d     = cnt_q;
    gnt_vld_d = 1'b0;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        gnt_d  = '0;
        if ((|elig) && out_nafull) begin
          state_d   = GRANT;
          gnt_vld_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          if (hp_win) begin
            gnt_id_d = '0;
          end else if (keep_ptr) begin
            gnt_id_d = ptr_q;
            credit_d = credit_q - WWID'(1);
          end else begin
            gnt_id_d = scan_id;
            ptr_d    = scan_id;
            credit_d = weight_q[scan_id] - WWID'(1);
          end
          gnt_d = UNUM'(1) << gnt_id_d;
        end
      end
      GRANT, HOLD: begin
        // cnt_q is the index of the current window cycle, GRANT being 0.
        if (cnt_nxt < CW'(WIN)) begin
          state_d = HOLD;
          cnt_d   = cnt_nxt;
          if (cnt_nxt >= CW'(CELLSZ)) gnt_d = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      credit_q  <= WWID'(WT_RST);
      cnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      credit_q  <= credit_d;
      cnt_q     <= cnt_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
    end
  end

  // Arbitration in the same cycle as a write still sees the old weight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < UNUM; i++) weight_q[i] <= WWID'(WT_RST);
    end else if (cfg_wen && ({1'b0, cfg_addr} < (ID_WID + 1)'(UNUM))) begin
      weight_q[cfg_addr] <= cfg_wdata;
    end
  end

  assign gnt_vld = gnt_vld_q;
  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign dbg_sig = DBG_WID'({state_q, ptr_q, credit_q});

endmodule
